// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns PC, IR, ACC, B and the latched ALU flags.
// Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB); HLT parks in HALT after EXEC.
// Backpressure: none; the instruction memory answers one cycle after imem_rd, and the ALU is combinational.
module cpu_control_unit #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [7:0]      instr,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  output logic [3:0]      alu_opcode,
  output logic            alu_en,
  input  logic [3:0]      alu_result,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_v,
  output logic [3:0]      out_data,
  output logic            out_valid,
  output logic            halted,
  output logic [3:0]      acc
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Non-ALU opcodes; any opcode with bit 3 set goes to the ALU.
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_JC  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b0111;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [3:0]      b_reg;
  // Latched flags, packed {Z, N, C, V}; only ALU instructions update them.
  logic [3:0]      flags;
  // Jump decision taken in EXEC and consumed by the PC update in WB.
  logic            take_jump;

  logic [3:0]      ir_op;
  logic [3:0]      ir_imm;
  logic [PC_W-1:0] jump_target;

  assign ir_op       = ir[7:4];
  assign ir_imm      = ir[3:0];
  assign jump_target = PC_W'(ir_imm);

  // The ALU operands are the architectural registers themselves, so they hold
  // their values whenever the ALU is not enabled.
  assign imem_addr  = pc;
  assign alu_a      = acc;
  assign alu_b      = b_reg;
  assign alu_opcode = ir_op;

  // Sequencer: state, architectural registers and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      acc       <= '0;
      b_reg     <= '0;
      flags     <= '0;
      take_jump <= 1'b0;
      imem_rd   <= 1'b0;
      alu_en    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      imem_rd   <= 1'b0;
      alu_en    <= 1'b0;
      out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            imem_rd <= 1'b1;
          end
        end

        FETCH: begin
          // Memory returns the word during DECODE.
          state <= DECODE;
        end

        DECODE: begin
          ir     <= instr;
          // ALU enable is registered so it is high for exactly the EXEC cycle.
          alu_en <= instr[7];
          state  <= EXEC;
        end

        EXEC: begin
          state     <= WB;
          take_jump <= 1'b0;
          if (ir_op[3]) begin
            acc   <= alu_result;
            flags <= {alu_z, alu_n, alu_c, alu_v};
          end else begin
            case (ir_op)
              OP_NOP: ;
              OP_LDA: acc   <= ir_imm;
              OP_LDB: b_reg <= ir_imm;
              OP_JMP: take_jump <= 1'b1;
              OP_JZ:  take_jump <= flags[3];
              OP_JC:  take_jump <= flags[1];
              OP_OUT: begin
                // Qualified output appears during WB only.
                out_data  <= acc;
                out_valid <= 1'b1;
              end
              OP_HLT: begin
                // PC stays on the HLT word; nothing advances from here.
                state  <= HALT;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        WB: begin
          if (take_jump) begin
            pc <= jump_target;
          end else begin
            pc <= pc + PC_W'(1);
          end
          take_jump <= 1'b0;
          state     <= FETCH;
          imem_rd   <= 1'b1;
        end

        HALT: begin
          // Frozen until reset; start is deliberately ignored.
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: synchronous instruction memory and reference ALU around the DUT,
// expected OUT values queued at program start and compared as out_valid pulses arrive,
// final ACC/flags and key fetch addresses checked against hand-derived values.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] imem_addr;
  logic       imem_rd;
  logic [7:0] instr = 8'h00;
  logic [3:0] alu_a, alu_b, alu_opcode;
  logic       alu_en;
  logic [3:0] alu_result;
  logic       alu_z, alu_n, alu_c, alu_v;
  logic [3:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] acc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_out_q[$];
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted),
    .acc        (acc)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous instruction memory: word valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) instr <= mem[imem_addr];
  end

  // Reference ALU: 8 ADD, 9 SUB, A AND, B OR, C XOR, D NOT, E SHL, F SHR.
  logic [4:0] sum5;
  always_comb begin
    sum5       = 5'd0;
    alu_result = 4'd0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_opcode)
      4'h8: begin
        sum5       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum5[3:0];
        alu_c      = sum5[4];
        alu_v      = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      4'h9: begin
        sum5       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = sum5[3:0];
        alu_c      = sum5[4];
        alu_v      = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      4'hA: alu_result = alu_a & alu_b;
      4'hB: alu_result = alu_a | alu_b;
      4'hC: alu_result = alu_a ^ alu_b;
      4'hD: alu_result = ~alu_a;
      4'hE: begin alu_result = {alu_a[2:0], 1'b0}; alu_c = alu_a[3]; end
      4'hF: begin alu_result = {1'b0, alu_a[3:1]}; alu_c = alu_a[0]; end
      default: alu_result = 4'd0;
    endcase
    alu_z = (alu_result == 4'd0);
    alu_n = alu_result[3];
  end

  // Scoreboard side: pop expected OUT values, and police strobe shapes.
  logic prev_ov = 1'b0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      check_val("out_pulse_width", prev_ov, 1'b0);
      if (exp_out_q.size() == 0) check_val("out_unexpected", out_valid, 1'b0);
      else check_val("out_data", out_data, exp_out_q.pop_front());
    end
    if (alu_en) begin
      check_val("alu_en_opcode", alu_opcode[3], 1'b1);
      check_val("alu_en_width", prev_en, 1'b0);
    end
    prev_ov = out_valid;
    prev_en = alu_en;
  end

  task automatic prog_reset();
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h70;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // After this returns the start edge has passed and the DUT is in FETCH.
  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 200 && !halted; i++) @(posedge clk);
    #1;
    if (!halted) check_val({tag, "_halt_timeout"}, halted, 1'b1);
  endtask

  task automatic check_final(input string tag, input logic [3:0] acc_e, input logic [3:0] flags_e);
    check_val({tag, "_acc"}, acc, acc_e);
    check_val({tag, "_flags_znCV"}, dut.flags, flags_e);
    check_val({tag, "_outs_pending"}, 16'(exp_out_q.size()), 16'd0);
  endtask

  initial begin
    #2;
    // Reset state
    check_val("rst_imem_addr", imem_addr, 4'd0);
    check_val("rst_imem_rd", imem_rd, 1'b0);
    check_val("rst_alu_en", alu_en, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 4'd0);
    check_val("rst_halted", halted, 1'b0);
    check_val("rst_acc", acc, 4'd0);
    check_val("rst_alu_b", alu_b, 4'd0);
    check_val("rst_alu_opcode", alu_opcode, 4'd0);

    // P1: LDA 2; LDB 3; ADD; OUT; HLT
    prog_reset();
    mem[0] = 8'h12; mem[1] = 8'h23; mem[2] = 8'h80; mem[3] = 8'h60; mem[4] = 8'h70;
    exp_out_q.push_back(4'h5);
    run_start();
    cycles(18);
    check_val("p1_not_yet_halted", halted, 1'b0);
    cycles(2);
    check_val("p1_halted_at_20", halted, 1'b1);
    check_val("p1_pc_on_hlt", imem_addr, 4'd4);
    check_final("p1", 4'h5, 4'b0000);
    // start in HALT has no effect
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(2);
    check_val("p1_halt_hold", halted, 1'b1);
    check_val("p1_halt_pc", imem_addr, 4'd4);
    check_val("p1_halt_no_fetch", imem_rd, 1'b0);
    check_val("p1_halt_acc", acc, 4'h5);

    // P2a: LDA 7; LDB 4; ADD -> 1011, N=1 V=1
    prog_reset();
    mem[0] = 8'h17; mem[1] = 8'h24; mem[2] = 8'h80; mem[3] = 8'h60;
    exp_out_q.push_back(4'hB);
    run_start();
    wait_halt("p2a");
    check_final("p2a", 4'hB, 4'b0101);

    // P2b: LDA 8; LDB 1; SUB -> 0111, V=1
    prog_reset();
    mem[0] = 8'h18; mem[1] = 8'h21; mem[2] = 8'h90; mem[3] = 8'h60;
    exp_out_q.push_back(4'h7);
    run_start();
    wait_halt("p2b");
    check_final("p2b", 4'h7, 4'b0001);

    // P3a: LDA 5; LDB 5; XOR; JZ 9 -> taken
    prog_reset();
    mem[0] = 8'h15; mem[1] = 8'h25; mem[2] = 8'hC0; mem[3] = 8'h49;
    mem[4] = 8'h60; mem[9] = 8'h1A; mem[10] = 8'h60;
    exp_out_q.push_back(4'hA);
    run_start();
    cycles(16);
    check_val("p3a_jz_target", imem_addr, 4'd9);
    wait_halt("p3a");
    check_final("p3a", 4'hA, 4'b1000);

    // P3b: B=4 -> Z=0, falls through to PC+1
    prog_reset();
    mem[0] = 8'h15; mem[1] = 8'h24; mem[2] = 8'hC0; mem[3] = 8'h49;
    mem[4] = 8'h60; mem[9] = 8'h1A; mem[10] = 8'h60;
    exp_out_q.push_back(4'h1);
    run_start();
    cycles(16);
    check_val("p3b_jz_fallthrough", imem_addr, 4'd4);
    wait_halt("p3b");
    check_final("p3b", 4'h1, 4'b0000);

    // P4: JMP 15 at address 3, NOP at 15, PC wraps to 0
    prog_reset();
    mem[0] = 8'h46; mem[1] = 8'h10; mem[2] = 8'hB0; mem[3] = 8'h3F;
    mem[15] = 8'h00; mem[6] = 8'h60;
    exp_out_q.push_back(4'h0);
    run_start();
    cycles(16);
    check_val("p4_jmp_15", imem_addr, 4'd15);
    cycles(4);
    check_val("p4_wrap_0", imem_addr, 4'd0);
    cycles(4);
    check_val("p4_jz_after_wrap", imem_addr, 4'd6);
    wait_halt("p4");
    check_final("p4", 4'h0, 4'b1000);

    // P5: reset during EXEC of ADD
    prog_reset();
    mem[0] = 8'h13; mem[1] = 8'h21; mem[2] = 8'h80; mem[3] = 8'h60;
    run_start();
    cycles(10);
    check_val("p5_exec_alu_en", alu_en, 1'b1);
    check_val("p5_exec_acc", acc, 4'h3);
    rst_n = 1'b0;
    #1;
    check_val("p5_abort_acc", acc, 4'h0);
    check_val("p5_abort_pc", imem_addr, 4'd0);
    check_val("p5_abort_alu_en", alu_en, 1'b0);
    check_val("p5_abort_flags", dut.flags, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(5);
    check_val("p5_idle_no_fetch", imem_rd, 1'b0);
    check_val("p5_idle_pc", imem_addr, 4'd0);
    check_val("p5_idle_acc", acc, 4'h0);
    exp_out_q.push_back(4'h4);
    run_start();
    wait_halt("p5");
    check_final("p5", 4'h4, 4'b0000);

    // P6: start pulsed during FETCH and in HALT; SHL 0011 -> 0110
    prog_reset();
    mem[0] = 8'h13; mem[1] = 8'hE0; mem[2] = 8'h60;
    exp_out_q.push_back(4'h6);
    run_start();
    cycles(4);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check_val("p6_fetch_start_ignored", imem_addr, 4'd1);
    wait_halt("p6");
    check_final("p6", 4'h6, 4'b0000);
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    check_val("p6_halt_hold", halted, 1'b1);
    check_val("p6_halt_pc", imem_addr, 4'd3);
    check_val("p6_halt_acc", acc, 4'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Fetch/decode/execute sequencer for the 4-bit CPU. It reads 8-bit instructions from a synchronous instruction memory and holds the accumulator (ACC), the B operand register and the latched flags. It drives the shared combinational ALU (operands, 4-bit opcode, enable), writes results back and handles jumps, output and halt.

Parameters:
PC_W, 4, program counter width; the instruction memory holds 2**PC_W words.
RESET_PC, 0, PC value after reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  starts execution from IDLE; ignored in every other state.
imem_addr  output  PC_W  instruction memory address (= PC).
imem_rd  output  1  memory read strobe; instr is valid the cycle after.
instr  input  8  instruction word: [7:4] opcode, [3:0] imm/addr.
alu_a  output  4  ALU operand A (= ACC).
alu_b  output  4  ALU operand B (= B register).
alu_opcode  output  4  ALU opcode (= IR[7:4]).
alu_en  output  1  ALU enable.
alu_result  input  4  ALU result.
alu_z, alu_n, alu_c, alu_v  input  1 each  ALU zero, negative, carry and overflow flags.
out_data  output  4  ACC value for the OUT instruction.
out_valid  output  1  one-cycle pulse qualifying out_data.
halted  output  1  high while in HALT.
acc  output  4  ACC, debug visibility.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, PC=RESET_PC, IR=0, ACC=0, B=0, flags Z/N/C/V=0.
  - All outputs 0, except imem_addr=RESET_PC.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE -> FETCH when start=1.
  - FETCH -> DECODE -> EXEC -> WB -> FETCH, unconditionally.
  - EXEC -> HALT for the HLT opcode.
- Every non-halting instruction takes exactly 4 cycles.
- FETCH: imem_rd=1 for one cycle.
- DECODE: IR <= instr.
- EXEC:
  - Opcode 1xxx (ALU ops): alu_en=1, alu_a=ACC, alu_b=B, alu_opcode=IR[7:4].
  - At the clock edge leaving EXEC: ACC <= alu_result and Z/N/C/V <= the ALU flags.
  - ALU sub-opcodes 1101/1110/1111 ignore B, but B is still driven.
  - alu_en=0 in all other states and for all non-ALU opcodes; alu_a/alu_b hold their values.
- Non-ALU opcodes (effect applied at the edge leaving EXEC; flags unchanged unless stated):
  - 0000 NOP.
  - 0001 LDA: ACC <= imm.
  - 0010 LDB: B <= imm.
  - 0011 JMP: next PC = imm.
  - 0100 JZ: jump to imm if Z=1.
  - 0101 JC: jump to imm if C=1.
  - 0110 OUT: out_data=ACC with out_valid=1 during WB.
  - 0111 HLT.
  - LDA and LDB do not modify flags.
  - Jump flags are the latched flags from the most recent ALU op.
- WB: PC <= jump target if taken, else PC+1, with modulo 2**PC_W wrap (15 -> 0).
- HALT:
  - halted=1; PC, ACC, B and flags are frozen.
  - start is ignored; only rst_n exits HALT, back to IDLE.
  - PC is not incremented past the HLT instruction.
- Reset asserted mid-instruction aborts immediately; no partial ACC, flag or PC update survives.
- start held high or pulsed while running has no effect.
- out_valid is never high outside WB.

Test Plan:
1. Program LDA 2; LDB 3; ADD(1000); OUT; HLT -> out_valid pulses once with out_data=0101; flags Z=N=C=V=0; halted=1 after 5 instructions (20 cycles after start).
2. LDA 7; LDB 4; ADD -> ACC=1011, N=1, V=1, C=0. Then LDB 1; SUB(1001) with ACC=1000 -> ACC=0111, V=1.
3. LDA 5; LDB 5; XOR(1100); JZ 9 -> imem_addr=9 at the following FETCH. With B=4 instead, Z=0 and the next fetch is at PC+1.
4. JMP 15 placed at address 3, NOP at address 15 -> the fetch after NOP reads address 0 (wrap).
5. Assert rst_n=0 during EXEC of an ALU op -> ACC, flags and PC read 0/RESET_PC immediately; alu_en=0; the block waits in IDLE for start.
6. Pulse start in HALT and during FETCH -> no state change; alu_en stays 0 in every non-EXEC cycle; SHL on ACC=0011 yields ACC=0110.
